// File: rtl/kyber_bits_to_bytes.sv
// kyber_bits_to_bytes
//   Kyber BitsToBytes: packs a BIT_LENGTH-bit vector into BYTE_LENGTH bytes,
//   LSB-first (bit i lands in byte i/8 with weight 2^(i mod 8)). The packed
//   bytes are held as a registered parallel array and replayed as a
//   ready/valid byte stream, index 0 first.
//
//   Optional feature: define KYBER_B2B_XOR_CHECK_EN to add xor_sum, the XOR
//   of all bytes, registered alongside byte_array.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     bit_array valid (accepted only while in_ready)
//   in_ready     idle, a new vector can be captured
//   bit_array    input vector, bit 0 first
//   byte_array   registered packed bytes [0:BYTE_LENGTH-1]
//   out_valid    byte_array holds a converted vector (level, cleared by reset)
//   byte_out     stream byte = byte_array[byte_idx]
//   byte_valid   byte_out valid (streaming)
//   byte_ready   downstream accepts byte_out
//   byte_idx     index of byte_out
//   byte_last    byte_out is the final byte
//   busy         streaming in progress
//   xor_sum      (KYBER_B2B_XOR_CHECK_EN only) XOR of all bytes
module kyber_bits_to_bytes #(
  parameter int BIT_LENGTH  = 2048,
  parameter int BYTE_LENGTH = 256,
  localparam int IDX_W = (BYTE_LENGTH > 1) ? $clog2(BYTE_LENGTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH-1:0] bit_array,
  output logic [7:0]            byte_array [0:BYTE_LENGTH-1],
  output logic                  out_valid,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [IDX_W-1:0]      byte_idx,
  output logic                  byte_last,
  output logic                  busy
`ifdef KYBER_B2B_XOR_CHECK_EN
  ,
  output logic [7:0]            xor_sum
`endif
);

  if ((BIT_LENGTH == 0) || (BIT_LENGTH % 8 != 0) || (BYTE_LENGTH * 8 != BIT_LENGTH)) begin : g_bad_params
    $fatal(1, "kyber_bits_to_bytes: BYTE_LENGTH must equal BIT_LENGTH/8 and BIT_LENGTH a non-zero multiple of 8");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_LENGTH - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    byte_valid = 1'b0;
    busy       = 1'b0;
    byte_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = STREAM;
      end
      STREAM: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_last  = (byte_idx == LAST_IDX);
        if (byte_ready && byte_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // byte_idx never exceeds LAST_IDX, so the read is always in range; after
  // reset the array is zero, which keeps byte_out at 0 as well.
  always_comb begin
    byte_out = byte_array[byte_idx];
  end

`ifdef KYBER_B2B_XOR_CHECK_EN
  logic [7:0] xor_next;

  always_comb begin
    xor_next = '0;
    for (int unsigned j = 0; j < BYTE_LENGTH; j++) begin
      xor_next = xor_next ^ bit_array[8*j +: 8];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < BYTE_LENGTH; j++) byte_array[j] <= '0;
      out_valid <= 1'b0;
      byte_idx  <= '0;
`ifdef KYBER_B2B_XOR_CHECK_EN
      xor_sum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned j = 0; j < BYTE_LENGTH; j++) byte_array[j] <= bit_array[8*j +: 8];
            out_valid <= 1'b1;
            byte_idx  <= '0;
`ifdef KYBER_B2B_XOR_CHECK_EN
            xor_sum   <= xor_next;
`endif
          end
        end
        STREAM: begin
          if (byte_ready) begin
            if (byte_idx == LAST_IDX) byte_idx <= '0;
            else                      byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        default: byte_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_bits_to_bytes.sv
// Testbench for kyber_bits_to_bytes (default 2048-bit / 256-byte build).
module tb_kyber_bits_to_bytes;
  localparam int BITS  = 2048;
  localparam int BYTES = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] bit_array;
  logic [7:0]      byte_array [0:BYTES-1];
  logic            out_valid;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
  logic [7:0]      byte_idx;
  logic            byte_last;
  logic            busy;
`ifdef KYBER_B2B_XOR_CHECK_EN
  logic [7:0]      xor_sum;
`endif

  kyber_bits_to_bytes #(.BIT_LENGTH(BITS), .BYTE_LENGTH(BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bit_array  (bit_array),
    .byte_array (byte_array),
    .out_valid  (out_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_idx   (byte_idx),
    .byte_last  (byte_last),
    .busy       (busy)
`ifdef KYBER_B2B_XOR_CHECK_EN
    ,
    .xor_sum    (xor_sum)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference: every set bit i adds 2^(i mod 8) to byte i/8.
  logic [7:0] mdl [BYTES];
  logic [7:0] mdl_xor;

  function automatic void model(input logic [BITS-1:0] v);
    for (int j = 0; j < BYTES; j++) mdl[j] = 8'h00;
    for (int i = 0; i < BITS; i++)
      if (v[i]) mdl[i / 8] = mdl[i / 8] + 8'(1 << (i % 8));
    mdl_xor = 8'h00;
    for (int j = 0; j < BYTES; j++) mdl_xor = mdl_xor ^ mdl[j];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_array(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int j = 0; j < BYTES; j++) begin
      if (byte_array[j] !== mdl[j]) begin
        bad++;
        if (first < 0) first = j;
      end
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s: %0d bytes differ, first idx %0d got %02h expected %02h",
               name, bad, first, byte_array[first], mdl[first]);
    end
  endtask

  task automatic capture(input logic [BITS-1:0] v);
    chk("in_ready before capture", 32'(in_ready), 1);
    in_valid  = 1'b1;
    bit_array = v;
    model(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid after capture", 32'(out_valid), 1);
    chk("in_ready in stream", 32'(in_ready), 0);
    chk("byte_valid after capture", 32'(byte_valid), 1);
    chk("busy after capture", 32'(busy), 1);
    chk("byte_idx start", 32'(byte_idx), 0);
    check_array("byte_array after capture");
`ifdef KYBER_B2B_XOR_CHECK_EN
    chk("xor_sum", 32'(xor_sum), 32'(mdl_xor));
`endif
  endtask

  // Streams bytes until stop_at have been accepted; rnd adds random stalls,
  // inject pulses in_valid with all-ones data while at byte 50.
  task automatic drain(input bit rnd, input int stop_at, input bit inject);
    int pos;
    int cyc;
    bit r;
    pos = 0;
    cyc = 0;
    while (pos < stop_at && cyc < 20 * BYTES) begin
      chk("byte_valid", 32'(byte_valid), 1);
      chk("byte_idx", 32'(byte_idx), 32'(pos));
      chk("byte_out", 32'(byte_out), 32'(mdl[pos]));
      chk("byte_last", 32'(byte_last), 32'(pos == BYTES - 1));
      r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_ready = r;
      if (inject && pos == 50) begin
        in_valid  = 1'b1;
        bit_array = '1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (r) pos++;
    end
    byte_ready = 1'b0;
    in_valid   = 1'b0;
    chk("bytes streamed within budget", 32'(pos), 32'(stop_at));
    if (stop_at == BYTES) begin
      chk("in_ready after stream", 32'(in_ready), 1);
      chk("byte_valid after stream", 32'(byte_valid), 0);
      chk("busy after stream", 32'(busy), 0);
      chk("byte_idx after stream", 32'(byte_idx), 0);
      chk("out_valid held", 32'(out_valid), 1);
      check_array("byte_array held after stream");
    end
  endtask

  typedef struct {
    logic [BITS-1:0] vec;
    int              idx;
    logic [7:0]      val;
    bit              rnd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [BITS-1:0] one_hot(input int b);
    logic [BITS-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [BITS-1:0] rand_vec();
    logic [BITS-1:0] v;
    for (int k = 0; k < BITS / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] v;

    // Bytes from the MSB end read 0x01,0x02,...,0xFF,0x00.
    for (int j = 0; j < BYTES; j++) cnt[8*j +: 8] = 8'((256 - j) % 256);
    tbl.push_back('{cnt, 0,   8'h00, 1'b0});
    tbl.push_back('{cnt, 1,   8'hFF, 1'b1});
    tbl.push_back('{cnt, 2,   8'hFE, 1'b1});
    tbl.push_back('{cnt, 254, 8'h02, 1'b1});
    tbl.push_back('{cnt, 255, 8'h01, 1'b1});
    tbl.push_back('{one_hot(9),    1,   8'h02, 1'b1});
    tbl.push_back('{one_hot(2047), 255, 8'h80, 1'b1});
    tbl.push_back('{one_hot(0),    0,   8'h01, 1'b0});
    tbl.push_back('{one_hot(7),    0,   8'h80, 1'b1});
    tbl.push_back('{one_hot(8),    1,   8'h01, 1'b1});
    tbl.push_back('{one_hot(1005), 125, 8'h20, 1'b1});

    rst        = 1'b1;
    in_valid   = 1'b0;
    byte_ready = 1'b0;
    bit_array  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model('0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset byte_valid", 32'(byte_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset byte_idx", 32'(byte_idx), 0);
    chk("reset byte_last", 32'(byte_last), 0);
    chk("reset byte_out", 32'(byte_out), 0);
    check_array("reset byte_array");
`ifdef KYBER_B2B_XOR_CHECK_EN
    chk("reset xor_sum", 32'(xor_sum), 0);
`endif
    @(negedge clk);

    // Table vectors, back to back: each capture lands in the first IDLE cycle.
    foreach (tbl[i]) begin
      capture(tbl[i].vec);
      chk($sformatf("table byte_array[%0d]", tbl[i].idx), 32'(byte_array[tbl[i].idx]), 32'(tbl[i].val));
      drain(tbl[i].rnd, BYTES, i == 1);
    end

    // Random vectors with random stalls and an ignored mid-stream capture.
    for (int k = 0; k < 6; k++) begin
      v = rand_vec();
      capture(v);
      drain(1'b1, BYTES, (k % 2) == 0);
      if (k == 2) repeat (3) @(negedge clk);
    end

    // Reset in the middle of a stream.
    capture(rand_vec());
    drain(1'b0, 100, 1'b0);
    chk("byte_idx before mid reset", 32'(byte_idx), 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model('0);
    chk("mid reset in_ready", 32'(in_ready), 1);
    chk("mid reset out_valid", 32'(out_valid), 0);
    chk("mid reset byte_valid", 32'(byte_valid), 0);
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset byte_idx", 32'(byte_idx), 0);
    check_array("mid reset byte_array");
`ifdef KYBER_B2B_XOR_CHECK_EN
    chk("mid reset xor_sum", 32'(xor_sum), 0);
`endif
    capture(rand_vec());
    drain(1'b1, BYTES, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/kyber_bits_to_bytes.md
Name: kyber_bits_to_bytes

Overview:
- Kyber BitsToBytes converter: packs a BIT_LENGTH-bit vector into BYTE_LENGTH bytes, LSB-first (byte j = bits 8j+7..8j, so bit i has weight 2^(i mod 8) in byte i/8).
- Registers the result as a parallel byte array.
- Replays the bytes as a ready/valid byte stream, index 0 first, for downstream hash/encode blocks in the Kyber-768 datapath.

Parameters:
- BIT_LENGTH, 2048: input vector width in bits; must be a non-zero multiple of 8.
- BYTE_LENGTH, 256: output byte count; must equal BIT_LENGTH/8, otherwise elaboration fails with a fatal error.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  bit_array valid
- in_ready  output  1  block can accept a new vector (high only in IDLE)
- bit_array  input  BIT_LENGTH  bit vector, bit 0 = first bit
- byte_array  output  BYTE_LENGTH x 8  unpacked array [0:BYTE_LENGTH-1] of packed bytes, registered
- out_valid  output  1  byte_array holds a converted vector
- byte_out  output  8  stream byte
- byte_valid  output  1  byte_out valid
- byte_ready  input  1  downstream accepts byte_out
- byte_idx  output  $clog2(BYTE_LENGTH)  index of byte_out
- byte_last  output  1  byte_out is byte BYTE_LENGTH-1
- busy  output  1  high in STREAM

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE. byte_array, byte_out, byte_idx, out_valid, byte_valid, byte_last and busy all clear to 0. in_ready is 1 the cycle after reset. Reset overrides any capture or stream transfer in progress.
- Mapping: byte_array[j][k] = bit_array[8j+k] for j in 0..BYTE_LENGTH-1 and k in 0..7. No bit reversal within a byte.
- IDLE state:
  - in_ready=1, byte_valid=0.
  - When in_valid=1, the vector is captured at that edge.
  - On the next cycle byte_array holds the mapped bytes, out_valid=1 (latency 1), state=STREAM and byte_idx=0.
- STREAM state:
  - in_ready=0; in_valid is ignored and bit_array is not sampled.
  - byte_valid=1, byte_out=byte_array[byte_idx], byte_last=(byte_idx==BYTE_LENGTH-1), busy=1.
  - byte_out/byte_idx stay stable while byte_ready=0.
  - On each edge with byte_ready=1, byte_idx increments.
  - When byte_ready=1 and byte_last=1, state returns to IDLE, byte_idx returns to 0 and byte_valid drops the next cycle.
- out_valid is a level, not a pulse. It stays 1 after the first capture and is cleared only by reset. byte_array holds its value until the next capture.
- back-to-back: a new vector can be captured in the first IDLE cycle after the last byte transfers. Minimum period is BYTE_LENGTH+1 cycles.
- BYTE_LENGTH=1: first stream byte is also last.

Optional Feature:
- Macro: KYBER_B2B_XOR_CHECK_EN.
- When defined: extra output xor_sum[7:0] = XOR of all BYTE_LENGTH bytes. It is registered in the same cycle as byte_array and reset to 0.
- When undefined: port xor_sum and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: in_ready=1; out_valid, byte_valid, busy and byte_array all 0.
- Capture the vector whose bytes from MSB down are 0x01,0x02,...,0xFF,0x00 (so bits[7:0]=0x00 and bits[2047:2040]=0x01), with in_valid for 1 cycle. Next cycle: out_valid=1, byte_array[0]=0x00, [1]=0xFF, [2]=0xFE, [254]=0x02, [255]=0x01. Optional xor_sum=0x00.
- Stream with byte_ready held 1: 256 consecutive bytes 0x00,0xFF,...,0x01 with byte_idx 0..255. byte_last only at idx 255. in_ready=1 the following cycle.
- Random byte_ready stalls: byte_out/byte_idx stay stable while ready=0. An in_valid pulse mid-stream with bit_array=all-ones is ignored: byte_array is unchanged, no bytes are lost or duplicated.
- Single-bit walk: bit_array with only bit 9 set -> byte_array[1]=0x02, every other byte 0. Only bit 2047 set -> byte_array[255]=0x80.
- Assert rst in the middle of the stream (byte_idx=100): next cycle IDLE, out_valid=0, byte_array all 0, byte_valid=0. A subsequent capture works normally.
